// File: rtl/cla_accum_stage.sv
// Valid/ready accumulator stage around an external combinational carry-lookahead adder.
// Sums i_len samples, then presents the total and a sticky carry-out flag.
module cla_accum_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_add1,
    output logic [WIDTH-1:0] o_add2,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                    if (i_len != '0) begin
                        rem_d   = i_len;
                        state_d = StAccum;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAccum: begin
                if (i_valid) begin
                    acc_d = i_sum;
                    ovf_d = ovf_q | i_carry;
                    cnt_d = cnt_q + CNT_W'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Adder operands are combinational so the sum returns within the same cycle.
    assign o_add1   = acc_q;
    assign o_add2   = i_data;
    assign o_result = acc_q;
    assign o_ovf    = ovf_q;
    assign o_count  = cnt_q;
    assign o_ready  = (state_q == StAccum);
    assign o_valid  = (state_q == StDone);
    assign o_busy   = (state_q == StAccum) || (state_q == StDone);

endmodule

// File: tb/tb_cla_accum_stage.sv
// Directed bench for cla_accum_stage; models the external adder combinationally.
module tb_cla_accum_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready_out;
    logic [WIDTH-1:0] add1;
    logic [WIDTH-1:0] add2;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic             valid_out;
    logic             ready;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    cla_accum_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_len   (len),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready_out),
        .o_add1  (add1),
        .o_add2  (add2),
        .i_sum   (sum),
        .i_carry (carry),
        .o_result(result),
        .o_ovf   (ovf),
        .o_count (count),
        .o_valid (valid_out),
        .i_ready (ready),
        .o_busy  (busy)
    );

    // Reference adder standing in for the carry-lookahead instance.
    logic [WIDTH:0] wide_sum;
    assign wide_sum = {1'b0, add1} + {1'b0, add2};
    assign sum      = wide_sum[WIDTH-1:0];
    assign carry    = wide_sum[WIDTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0]       vpat;
    logic [WIDTH-1:0] samples [4];
    int               si;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        data  = '0;
        valid = 1'b0;
        ready = 1'b0;
        #3;
        check("rst_ready", 64'(ready_out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_add1", 64'(add1), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        #9;
        rst_n = 1'b1;
        tick();

        // Basic sum 1+2+3
        ready = 1'b1;
        start = 1'b1;
        len   = 8'd3;
        tick();
        start = 1'b0;
        check("basic_accum_ready", 64'(ready_out), 64'd1);
        check("basic_accum_busy", 64'(busy), 64'd1);
        valid = 1'b1;
        data  = 32'd1;
        tick();
        data  = 32'd2;
        tick();
        data  = 32'd3;
        check("basic_add1", 64'(add1), 64'd3);
        check("basic_add2", 64'(add2), 64'd3);
        tick();
        valid = 1'b0;
        check("basic_valid", 64'(valid_out), 64'd1);
        check("basic_result", 64'(result), 64'd6);
        check("basic_ovf", 64'(ovf), 64'd0);
        check("basic_count", 64'(count), 64'd3);
        check("basic_done_ready", 64'(ready_out), 64'd0);
        tick();
        check("basic_valid_one_cycle", 64'(valid_out), 64'd0);
        check("basic_idle_busy", 64'(busy), 64'd0);
        check("basic_result_held", 64'(result), 64'd6);
        check("basic_count_held", 64'(count), 64'd3);

        // Overflow wrap
        ready = 1'b0;
        start = 1'b1;
        len   = 8'd2;
        tick();
        start = 1'b0;
        valid = 1'b1;
        data  = 32'hFFFF_FFFF;
        tick();
        check("wrap_first_ovf", 64'(ovf), 64'd0);
        data = 32'h0000_0002;
        tick();
        valid = 1'b0;
        check("wrap_valid", 64'(valid_out), 64'd1);
        check("wrap_result", 64'(result), 64'h1);
        check("wrap_ovf", 64'(ovf), 64'd1);
        tick();
        check("wrap_ovf_done_hold", 64'(ovf), 64'd1);
        check("wrap_valid_hold", 64'(valid_out), 64'd1);
        ready = 1'b1;
        tick();
        check("wrap_idle", 64'(busy), 64'd0);
        check("wrap_ovf_after_idle", 64'(ovf), 64'd1);

        // Zero length
        ready = 1'b0;
        start = 1'b1;
        len   = 8'd0;
        valid = 1'b1;
        data  = 32'd99;
        tick();
        start = 1'b0;
        check("zero_valid", 64'(valid_out), 64'd1);
        check("zero_result", 64'(result), 64'd0);
        check("zero_ovf", 64'(ovf), 64'd0);
        check("zero_count", 64'(count), 64'd0);
        check("zero_ready", 64'(ready_out), 64'd0);
        tick();
        check("zero_still_done", 64'(valid_out), 64'd1);
        check("zero_result_hold", 64'(result), 64'd0);
        valid = 1'b0;
        ready = 1'b1;
        tick();
        check("zero_idle", 64'(busy), 64'd0);

        // Stalls: valid pattern 1,0,0,1,1,0,1 carrying 5,6,7,8
        ready      = 1'b0;
        vpat       = 7'b1011001;
        samples[0] = 32'd5;
        samples[1] = 32'd6;
        samples[2] = 32'd7;
        samples[3] = 32'd8;
        start      = 1'b1;
        len        = 8'd4;
        tick();
        start = 1'b0;
        si    = 0;
        for (int k = 0; k < 7; k++) begin
            valid = vpat[k];
            data  = vpat[k] ? samples[si] : 32'hDEAD_BEEF;
            tick();
            if (vpat[k]) si++;
        end
        valid = 1'b0;
        check("stall_valid", 64'(valid_out), 64'd1);
        check("stall_result", 64'(result), 64'd26);
        check("stall_count", 64'(count), 64'd4);
        start = 1'b1;
        len   = 8'd9;
        for (int k = 0; k < 5; k++) begin
            data = 32'(k + 1000);
            tick();
            check($sformatf("stall_hold_valid_%0d", k), 64'(valid_out), 64'd1);
            check($sformatf("stall_hold_result_%0d", k), 64'(result), 64'd26);
            check($sformatf("stall_hold_count_%0d", k), 64'(count), 64'd4);
            check($sformatf("stall_hold_ovf_%0d", k), 64'(ovf), 64'd0);
        end
        // Start coincident with the DONE handshake must not launch a transaction.
        ready = 1'b1;
        tick();
        start = 1'b0;
        check("stall_idle", 64'(busy), 64'd0);
        check("stall_idle_valid", 64'(valid_out), 64'd0);
        tick();
        check("handshake_start_ignored", 64'(busy), 64'd0);
        check("handshake_result_kept", 64'(result), 64'd26);

        // Spurious start during ACCUM
        start = 1'b1;
        len   = 8'd2;
        tick();
        start = 1'b0;
        valid = 1'b1;
        data  = 32'd10;
        tick();
        valid = 1'b0;
        start = 1'b1;
        len   = 8'd9;
        tick();
        start = 1'b0;
        check("spur_busy", 64'(busy), 64'd1);
        check("spur_ready", 64'(ready_out), 64'd1);
        check("spur_count", 64'(count), 64'd1);
        valid = 1'b1;
        data  = 32'd20;
        tick();
        valid = 1'b0;
        check("spur_valid", 64'(valid_out), 64'd1);
        check("spur_count_done", 64'(count), 64'd2);
        check("spur_result", 64'(result), 64'd30);
        tick();

        // Asynchronous reset after 2 of 4 samples
        ready = 1'b0;
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        valid = 1'b1;
        data  = 32'd100;
        tick();
        data = 32'd200;
        tick();
        valid = 1'b0;
        check("mid_count", 64'(count), 64'd2);
        check("mid_result", 64'(result), 64'd300);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(ready_out), 64'd0);
        check("arst_valid", 64'(valid_out), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        #2;
        rst_n = 1'b1;
        valid = 1'b1;
        data  = 32'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_rst_busy_%0d", k), 64'(busy), 64'd0);
            check($sformatf("post_rst_result_%0d", k), 64'(result), 64'd0);
        end
        valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
